// File: rtl/pause_fader.sv
`default_nettype none
// ============================================================================
//  Module   : pause_fader
//  Purpose  : Merges pause sources into one CPU pause, adds single-frame
//             stepping while user-paused, and dims the video after a long
//             pause, either by a fixed halving or by a gradual fade.
//  Revision : 1.0  initial release
// ============================================================================
module pause_fader #(
  parameter int RW          = 8,
  parameter int GW          = 8,
  parameter int BW          = 8,
  parameter int CLKSPD      = 12,
  parameter int DIM_SECS    = 10,
  parameter int unsigned DIM_CYCLES = CLKSPD * 1000000 * DIM_SECS,
  parameter int NREQ        = 2,
  parameter int FADE_FRAMES = 30,
  parameter int FADE_MAX    = 4
) (
  input  logic                  clk_sys,
  input  logic                  reset,
  input  logic                  user_button,
  input  logic                  step_button,
  input  logic [NREQ-1:0]       pause_request,
  input  logic [2:0]            options,
  input  logic                  OSD_STATUS,
  input  logic                  vblank,
  input  logic [RW-1:0]         r,
  input  logic [GW-1:0]         g,
  input  logic [BW-1:0]         b,
  output logic                  pause_cpu,
  output logic [2:0]            dim_level,
  output logic                  stepping,
  output logic [RW+GW+BW-1:0]   rgb_out
);

  localparam logic [31:0] DIM_LIMIT  = 32'(DIM_CYCLES);
  localparam logic [7:0]  FADE_LIMIT = 8'(FADE_FRAMES);
  localparam logic [2:0]  FADE_TOP   = 3'(FADE_MAX);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    PAUSED = 2'd1,
    STEP   = 2'd2
  } state_t;

  state_t      state;
  logic        user_q;
  logic        step_q;
  logic        vblank_q;
  logic [31:0] dim_timer;
  logic [7:0]  frame_cnt;

  logic user_rise;
  logic step_rise;
  logic vblank_rise;
  logic timer_clear;

  assign user_rise   = user_button & ~user_q;
  assign step_rise   = step_button & ~step_q;
  assign vblank_rise = vblank & ~vblank_q;

  // Pause is forced low while reset is held so the CPU gating releases at once.
  assign pause_cpu = (|pause_request | (state == PAUSED) | (OSD_STATUS & options[0])) & ~reset;

  assign timer_clear = ~pause_cpu | ~options[1];

  // Previous-cycle copies of the level inputs for rising-edge detection.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      user_q   <= 1'b0;
      step_q   <= 1'b0;
      vblank_q <= 1'b0;
    end else begin
      user_q   <= user_button;
      step_q   <= step_button;
      vblank_q <= vblank;
    end
  end

  // Run/pause/step controller; a user rise always beats a step or vblank rise.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state    <= RUN;
      stepping <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (user_rise) state <= PAUSED;
          stepping <= 1'b0;
        end
        PAUSED: begin
          if (user_rise) begin
            state    <= RUN;
            stepping <= 1'b0;
          end else if (step_rise) begin
            state    <= STEP;
            stepping <= 1'b1;
          end
        end
        STEP: begin
          if (user_rise) begin
            state    <= RUN;
            stepping <= 1'b0;
          end else if (vblank_rise) begin
            state    <= PAUSED;
            stepping <= 1'b0;
          end
        end
        default: begin
          state    <= RUN;
          stepping <= 1'b0;
        end
      endcase
    end
  end

  // Pause-duration timer and dim level; everything drops to zero together
  // whenever the pause lapses or dimming is disabled.
  always_ff @(posedge clk_sys) begin
    if (reset || timer_clear) begin
      dim_timer <= 32'd0;
      dim_level <= 3'd0;
      frame_cnt <= 8'd0;
    end else begin
      if (dim_timer != DIM_LIMIT) dim_timer <= dim_timer + 32'd1;
      if (dim_level == 3'd0) begin
        if (dim_timer == DIM_LIMIT) dim_level <= 3'd1;
      end else if (options[2] && vblank_rise) begin
        if (frame_cnt + 8'd1 == FADE_LIMIT) begin
          frame_cnt <= 8'd0;
          if (dim_level < FADE_TOP) dim_level <= dim_level + 3'd1;
        end else begin
          frame_cnt <= frame_cnt + 8'd1;
        end
      end
    end
  end

  // Video path: one register stage, each channel shifted by the current level.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      rgb_out <= '0;
    end else begin
      rgb_out <= {r >> dim_level, g >> dim_level, b >> dim_level};
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pause_fader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pause_fader
//  Purpose  : Directed self-checking bench for pause_fader.
//  Revision : 1.0  initial release
// ============================================================================
module tb_pause_fader;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic        user_button;
  logic        step_button;
  logic [1:0]  pause_request;
  logic [2:0]  options;
  logic        OSD_STATUS;
  logic        vblank;
  logic [7:0]  r, g, b;
  logic        pause_cpu;
  logic [2:0]  dim_level;
  logic        stepping;
  logic [23:0] rgb_out;

  int checks = 0;
  int errors = 0;

  always #5 clk_sys = ~clk_sys;

  pause_fader #(
    .RW(8), .GW(8), .BW(8), .CLKSPD(12), .DIM_SECS(10),
    .DIM_CYCLES(100), .NREQ(2), .FADE_FRAMES(2), .FADE_MAX(3)
  ) dut (
    .clk_sys(clk_sys), .reset(reset), .user_button(user_button),
    .step_button(step_button), .pause_request(pause_request),
    .options(options), .OSD_STATUS(OSD_STATUS), .vblank(vblank),
    .r(r), .g(g), .b(b), .pause_cpu(pause_cpu), .dim_level(dim_level),
    .stepping(stepping), .rgb_out(rgb_out)
  );

  task automatic pulse_user();
    @(negedge clk_sys) user_button = 1'b1;
    @(negedge clk_sys) user_button = 1'b0;
  endtask

  task automatic pulse_step();
    @(negedge clk_sys) step_button = 1'b1;
    @(negedge clk_sys) step_button = 1'b0;
  endtask

  task automatic pulse_vblank();
    @(negedge clk_sys) vblank = 1'b1;
    @(negedge clk_sys) vblank = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; user_button = 0; step_button = 0; pause_request = 0;
    options = 0; OSD_STATUS = 0; vblank = 0; r = 8'hF0; g = 8'hF0; b = 8'hF0;
    repeat (3) @(negedge clk_sys);
    checks++;
    if (rgb_out !== 24'h0) begin errors++; $display("FAIL reset_rgb got %h want %h", rgb_out, 24'h0); end
    checks++;
    if (pause_cpu !== 1'b0) begin errors++; $display("FAIL reset_pause got %b want 0", pause_cpu); end
    checks++;
    if (dim_level !== 3'd0 || stepping !== 1'b0) begin errors++; $display("FAIL reset_state got dim=%0d step=%b want 0 0", dim_level, stepping); end
    reset = 1'b0;
    @(negedge clk_sys);
    checks++;
    if (rgb_out !== 24'hF0F0F0) begin errors++; $display("FAIL post_reset_rgb got %h want %h", rgb_out, 24'hF0F0F0); end
  endtask

  task automatic test_dim();
    options = 3'b010;
    pulse_user();
    checks++;
    if (pause_cpu !== 1'b1) begin errors++; $display("FAIL dim_pause got %b want 1", pause_cpu); end
    repeat (100) @(negedge clk_sys);
    checks++;
    if (dim_level !== 3'd0) begin errors++; $display("FAIL dim_before_timeout got %0d want 0", dim_level); end
    @(negedge clk_sys);
    checks++;
    if (dim_level !== 3'd1) begin errors++; $display("FAIL dim_at_timeout got %0d want 1", dim_level); end
    repeat (5) @(negedge clk_sys);
    checks++;
    if (dim_level !== 3'd1 || rgb_out !== 24'h787878) begin errors++; $display("FAIL dim_hold got dim=%0d rgb=%h want 1 787878", dim_level, rgb_out); end
    pulse_vblank(); pulse_vblank(); pulse_vblank();
    checks++;
    if (dim_level !== 3'd1) begin errors++; $display("FAIL dim_no_fade got %0d want 1", dim_level); end
    pulse_user();
    checks++;
    if (pause_cpu !== 1'b0) begin errors++; $display("FAIL unpause got %b want 0", pause_cpu); end
    @(negedge clk_sys);
    checks++;
    if (dim_level !== 3'd0) begin errors++; $display("FAIL undim got %0d want 0", dim_level); end
    @(negedge clk_sys);
    checks++;
    if (rgb_out !== 24'hF0F0F0) begin errors++; $display("FAIL undim_rgb got %h want F0F0F0", rgb_out); end
  endtask

  task automatic test_fade();
    options = 3'b110;
    pulse_user();
    repeat (102) @(negedge clk_sys);
    checks++;
    if (dim_level !== 3'd1) begin errors++; $display("FAIL fade_start got %0d want 1", dim_level); end
    pulse_vblank();
    checks++;
    if (dim_level !== 3'd1) begin errors++; $display("FAIL fade_one_rise got %0d want 1", dim_level); end
    pulse_vblank();
    checks++;
    if (dim_level !== 3'd2) begin errors++; $display("FAIL fade_two_rises got %0d want 2", dim_level); end
    @(negedge clk_sys);
    checks++;
    if (rgb_out !== 24'h3C3C3C) begin errors++; $display("FAIL fade_rgb2 got %h want 3C3C3C", rgb_out); end
    pulse_vblank(); pulse_vblank();
    checks++;
    if (dim_level !== 3'd3) begin errors++; $display("FAIL fade_four_rises got %0d want 3", dim_level); end
    pulse_vblank(); pulse_vblank();
    @(negedge clk_sys);
    checks++;
    if (dim_level !== 3'd3 || rgb_out !== 24'h1E1E1E) begin errors++; $display("FAIL fade_saturate got dim=%0d rgb=%h want 3 1E1E1E", dim_level, rgb_out); end
    options = 3'b010;
    pulse_vblank(); pulse_vblank();
    checks++;
    if (dim_level !== 3'd3) begin errors++; $display("FAIL fade_disable_hold got %0d want 3", dim_level); end
    options = 3'b000;
    @(negedge clk_sys);
    checks++;
    if (dim_level !== 3'd0) begin errors++; $display("FAIL dim_disable_clear got %0d want 0", dim_level); end
    pulse_user();
    checks++;
    if (pause_cpu !== 1'b0) begin errors++; $display("FAIL fade_unpause got %b want 0", pause_cpu); end
  endtask

  task automatic test_step();
    options = 3'b000;
    pulse_step();
    checks++;
    if (stepping !== 1'b0 || pause_cpu !== 1'b0) begin errors++; $display("FAIL step_in_run got step=%b pause=%b want 0 0", stepping, pause_cpu); end
    pulse_user();
    pulse_step();
    checks++;
    if (stepping !== 1'b1 || pause_cpu !== 1'b0) begin errors++; $display("FAIL step_enter got step=%b pause=%b want 1 0", stepping, pause_cpu); end
    pulse_step();
    checks++;
    if (stepping !== 1'b1) begin errors++; $display("FAIL step_ignore_step got %b want 1", stepping); end
    pulse_vblank();
    checks++;
    if (stepping !== 1'b0 || pause_cpu !== 1'b1) begin errors++; $display("FAIL step_exit got step=%b pause=%b want 0 1", stepping, pause_cpu); end
    pause_request = 2'b10;
    pulse_step();
    checks++;
    if (stepping !== 1'b1 || pause_cpu !== 1'b1) begin errors++; $display("FAIL step_req_hold got step=%b pause=%b want 1 1", stepping, pause_cpu); end
    pulse_vblank();
    checks++;
    if (stepping !== 1'b0 || pause_cpu !== 1'b1) begin errors++; $display("FAIL step_req_exit got step=%b pause=%b want 0 1", stepping, pause_cpu); end
    pause_request = 2'b00;
    // Enter STEP again, then user and vblank rise together: user wins.
    pulse_step();
    @(negedge clk_sys) begin user_button = 1'b1; vblank = 1'b1; end
    @(negedge clk_sys) begin user_button = 1'b0; vblank = 1'b0; end
    checks++;
    if (stepping !== 1'b0 || pause_cpu !== 1'b0) begin errors++; $display("FAIL step_user_prio got step=%b pause=%b want 0 0", stepping, pause_cpu); end
  endtask

  task automatic test_simultaneous();
    logic seen_step;
    pulse_user();
    seen_step = 1'b0;
    @(negedge clk_sys) begin user_button = 1'b1; step_button = 1'b1; end
    @(negedge clk_sys) begin user_button = 1'b0; step_button = 1'b0; end
    for (int i = 0; i < 4; i++) begin
      if (stepping) seen_step = 1'b1;
      @(negedge clk_sys);
    end
    checks++;
    if (seen_step !== 1'b0 || pause_cpu !== 1'b0) begin errors++; $display("FAIL simul_user_step got seen_step=%b pause=%b want 0 0", seen_step, pause_cpu); end
  endtask

  task automatic test_osd_reset();
    options = 3'b001; OSD_STATUS = 1'b1;
    @(negedge clk_sys);
    checks++;
    if (pause_cpu !== 1'b1) begin errors++; $display("FAIL osd_pause got %b want 1", pause_cpu); end
    options = 3'b000;
    #1;
    checks++;
    if (pause_cpu !== 1'b0) begin errors++; $display("FAIL osd_masked got %b want 0", pause_cpu); end
    OSD_STATUS = 1'b0;
    // Reset while stepping, with another source holding pause and the dim active.
    options = 3'b010; pause_request = 2'b01;
    pulse_user();
    pulse_step();
    repeat (102) @(negedge clk_sys);
    checks++;
    if (stepping !== 1'b1 || pause_cpu !== 1'b1 || dim_level !== 3'd1) begin errors++; $display("FAIL pre_reset got step=%b pause=%b dim=%0d want 1 1 1", stepping, pause_cpu, dim_level); end
    reset = 1'b1;
    #1;
    checks++;
    if (pause_cpu !== 1'b0) begin errors++; $display("FAIL reset_comb_pause got %b want 0", pause_cpu); end
    @(negedge clk_sys);
    checks++;
    if (stepping !== 1'b0 || dim_level !== 3'd0 || rgb_out !== 24'h0) begin errors++; $display("FAIL mid_step_reset got step=%b dim=%0d rgb=%h want 0 0 0", stepping, dim_level, rgb_out); end
    reset = 1'b0; pause_request = 2'b00;
    repeat (3) @(negedge clk_sys);
    checks++;
    if (pause_cpu !== 1'b0 || stepping !== 1'b0 || dim_level !== 3'd0) begin errors++; $display("FAIL post_reset_run got pause=%b step=%b dim=%0d want 0 0 0", pause_cpu, stepping, dim_level); end
  endtask

  initial begin
    test_reset();
    test_dim();
    test_fade();
    test_step();
    test_simultaneous();
    test_osd_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
